// File: rtl/dice_round_ctrl.sv
// rtl/dice_round_ctrl.sv - N-player round-based dice game controller
//
// Players roll in turn; after each full round every player holding the highest
// roll scores a point (saturating at WIN_SCORE). The first player(s) to reach
// WIN_SCORE win the game.
//
// Optional feature macro: DICE_TIE_REROLL_EN
//   defined   : a tied highest roll awards nothing, pulses tieReroll and the
//               round is replayed from player 0.
//   undefined : every tied player scores; tieReroll does not exist.
//
// Ports:
//   fastClk    in   game clock, rising edge
//   resetN     in   asynchronous active-low reset
//   enable     in   game power switch; low forces OFF and clears the game
//   rollN      in   raw active-low roll button (asynchronous)
//   newGameN   in   raw active-low new-game button (asynchronous)
//   state      out  00 OFF, 01 ROLL, 10 SCORE, 11 WON
//   curPlayer  out  index of the player whose turn it is
//   lastRoll   out  most recent roll value, 0 = blank
//   rollValid  out  1-cycle pulse when lastRoll updates
//   scores     out  packed scores, player i at [i*SW +: SW]
//   tieReroll  out  1-cycle pulse on a replayed tied round (macro builds only)
//   winnerMask out  bit i set = player i has won; valid in WON
module dice_round_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int FACES       = 6,
    parameter int WIN_SCORE   = 5,
    localparam int PW = $clog2(NUM_PLAYERS),
    localparam int RW = $clog2(FACES + 1),
    localparam int SW = $clog2(WIN_SCORE + 1)
) (
    input  logic                      fastClk,
    input  logic                      resetN,
    input  logic                      enable,
    input  logic                      rollN,
    input  logic                      newGameN,
    output logic [1:0]                state,
    output logic [PW-1:0]             curPlayer,
    output logic [RW-1:0]             lastRoll,
    output logic                      rollValid,
    output logic [NUM_PLAYERS*SW-1:0] scores,
`ifdef DICE_TIE_REROLL_EN
    output logic                      tieReroll,
`endif
    output logic [NUM_PLAYERS-1:0]    winnerMask
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ROLL  = 2'b01,
        ST_SCORE = 2'b10,
        ST_WON   = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          cur_q, cur_d;
    logic [RW-1:0]          last_q, last_d;
    logic                   valid_q, valid_d;
    logic [SW-1:0]          score_q   [NUM_PLAYERS];
    logic [SW-1:0]          score_d   [NUM_PLAYERS];
    logic [SW-1:0]          score_upd [NUM_PLAYERS];
    logic [RW-1:0]          roll_q    [NUM_PLAYERS];
    logic [RW-1:0]          roll_d    [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] win_q, win_d;
    logic [NUM_PLAYERS-1:0] at_max, won_upd;
    logic [RW-1:0]          max_roll;
    logic                   any_win;
    logic                   clear_game;
    logic [RW-1:0]          die_q;
    logic [2:0]             roll_sync, new_sync;
    logic                   roll_pulse, new_pulse;
`ifdef DICE_TIE_REROLL_EN
    logic                   tie_q, tie_d;
    logic                   multi_max;
`endif

    // Two flops resynchronise the buttons; the third holds the previous
    // synchronised level so a press (1 -> 0) yields exactly one pulse.
    always_ff @(posedge fastClk or negedge resetN) begin
        if (!resetN) begin
            roll_sync <= 3'b111;
            new_sync  <= 3'b111;
            die_q     <= RW'(1);
        end else begin
            roll_sync <= {roll_sync[1:0], rollN};
            new_sync  <= {new_sync[1:0], newGameN};
            die_q     <= (die_q == RW'(FACES)) ? RW'(1) : die_q + RW'(1);
        end
    end

    assign roll_pulse = roll_sync[2] & ~roll_sync[1];
    assign new_pulse  = new_sync[2] & ~new_sync[1];

    // Round evaluation: every player holding the highest roll gets a point.
    always_comb begin
        max_roll = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (roll_q[i] > max_roll) max_roll = roll_q[i];
        end
        any_win = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            at_max[i]    = (roll_q[i] == max_roll);
            score_upd[i] = (at_max[i] && score_q[i] != SW'(WIN_SCORE))
                           ? score_q[i] + SW'(1) : score_q[i];
            won_upd[i]   = (score_upd[i] == SW'(WIN_SCORE));
            any_win      = any_win | won_upd[i];
        end
    end

`ifdef DICE_TIE_REROLL_EN
    // More than one bit set in at_max means a shared highest roll.
    assign multi_max = (at_max & (at_max - 1'b1)) != '0;
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        last_d     = last_q;
        valid_d    = 1'b0;
        win_d      = win_q;
        clear_game = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            score_d[i] = score_q[i];
            roll_d[i]  = roll_q[i];
        end
`ifdef DICE_TIE_REROLL_EN
        tie_d = 1'b0;
`endif
        if (!enable) begin
            state_d    = ST_OFF;
            clear_game = 1'b1;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_ROLL;
                    clear_game = 1'b1;
                end
                ST_ROLL: begin
                    if (new_pulse) begin
                        clear_game = 1'b1;
                    end else if (roll_pulse) begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (PW'(i) == cur_q) roll_d[i] = die_q;
                        end
                        last_d  = die_q;
                        valid_d = 1'b1;
                        if (cur_q == PW'(NUM_PLAYERS - 1)) state_d = ST_SCORE;
                        else                               cur_d   = cur_q + PW'(1);
                    end
                end
                ST_SCORE: begin
                    cur_d = '0;
                    if (new_pulse) begin
                        state_d    = ST_ROLL;
                        clear_game = 1'b1;
                    end
`ifdef DICE_TIE_REROLL_EN
                    else if (multi_max) begin
                        tie_d   = 1'b1;
                        state_d = ST_ROLL;
                    end
`endif
                    else begin
                        for (int i = 0; i < NUM_PLAYERS; i++) score_d[i] = score_upd[i];
                        if (any_win) begin
                            state_d = ST_WON;
                            win_d   = won_upd;
                            last_d  = '0;
                        end else begin
                            state_d = ST_ROLL;
                        end
                    end
                end
                ST_WON: begin
                    last_d = '0;
                    if (new_pulse) begin
                        state_d    = ST_ROLL;
                        clear_game = 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
        if (clear_game) begin
            cur_d  = '0;
            last_d = '0;
            win_d  = '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_d[i] = '0;
                roll_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge fastClk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_OFF;
            cur_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            win_q   <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= '0;
                roll_q[i]  <= '0;
            end
`ifdef DICE_TIE_REROLL_EN
            tie_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            win_q   <= win_d;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= score_d[i];
                roll_q[i]  <= roll_d[i];
            end
`ifdef DICE_TIE_REROLL_EN
            tie_q <= tie_d;
`endif
        end
    end

    assign state      = state_q;
    assign curPlayer  = cur_q;
    assign lastRoll   = last_q;
    assign rollValid  = valid_q;
    assign winnerMask = win_q;
`ifdef DICE_TIE_REROLL_EN
    assign tieReroll  = tie_q;
`endif

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
        assign scores[g*SW +: SW] = score_q[g];
    end

endmodule

// File: tb/tb_dice_round_ctrl.sv
// tb/tb_dice_round_ctrl.sv - directed bench for dice_round_ctrl
module tb_dice_round_ctrl;
    localparam int FACES = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       enable;
    logic [2:0] roll_n;
    logic [2:0] new_n;

    // u2: 2 players, WIN_SCORE 5
    logic [1:0] st2; logic cp2;       logic [2:0] lr2; logic rv2; logic [5:0] sc2; logic [1:0] wm2;
    // u3: 3 players, WIN_SCORE 2
    logic [1:0] st3; logic [1:0] cp3; logic [2:0] lr3; logic rv3; logic [5:0] sc3; logic [2:0] wm3;
    // u4: 2 players, WIN_SCORE 2
    logic [1:0] st4; logic cp4;       logic [2:0] lr4; logic rv4; logic [3:0] sc4; logic [1:0] wm4;
`ifdef DICE_TIE_REROLL_EN
    logic tr2, tr3, tr4;
`endif

    dice_round_ctrl #(.NUM_PLAYERS(2), .FACES(FACES), .WIN_SCORE(5)) u2 (
        .fastClk(clk), .resetN(reset_n), .enable(enable), .rollN(roll_n[0]), .newGameN(new_n[0]),
        .state(st2), .curPlayer(cp2), .lastRoll(lr2), .rollValid(rv2), .scores(sc2),
`ifdef DICE_TIE_REROLL_EN
        .tieReroll(tr2),
`endif
        .winnerMask(wm2));

    dice_round_ctrl #(.NUM_PLAYERS(3), .FACES(FACES), .WIN_SCORE(2)) u3 (
        .fastClk(clk), .resetN(reset_n), .enable(enable), .rollN(roll_n[1]), .newGameN(new_n[1]),
        .state(st3), .curPlayer(cp3), .lastRoll(lr3), .rollValid(rv3), .scores(sc3),
`ifdef DICE_TIE_REROLL_EN
        .tieReroll(tr3),
`endif
        .winnerMask(wm3));

    dice_round_ctrl #(.NUM_PLAYERS(2), .FACES(FACES), .WIN_SCORE(2)) u4 (
        .fastClk(clk), .resetN(reset_n), .enable(enable), .rollN(roll_n[2]), .newGameN(new_n[2]),
        .state(st4), .curPlayer(cp4), .lastRoll(lr4), .rollValid(rv4), .scores(sc4),
`ifdef DICE_TIE_REROLL_EN
        .tieReroll(tr4),
`endif
        .winnerMask(wm4));

    // Reference die counter: 1..FACES from reset, one step per clock.
    int die_m;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) die_m <= 1;
        else          die_m <= (die_m == FACES) ? 1 : die_m + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int k, output logic [1:0] st, output logic [1:0] cp,
                          output logic [2:0] lr, output logic rv, output logic tr);
        tr = 1'b0;
        case (k)
            0: begin
                st = st2; cp = {1'b0, cp2}; lr = lr2; rv = rv2;
`ifdef DICE_TIE_REROLL_EN
                tr = tr2;
`endif
            end
            1: begin
                st = st3; cp = cp3; lr = lr3; rv = rv3;
`ifdef DICE_TIE_REROLL_EN
                tr = tr3;
`endif
            end
            default: begin
                st = st4; cp = {1'b0, cp4}; lr = lr4; rv = rv4;
`ifdef DICE_TIE_REROLL_EN
                tr = tr4;
`endif
            end
        endcase
    endtask

    // Presses roll on instance k timed so the captured die value is 'value'.
    // The pulse is seen in the cycle after the second edge following the press,
    // so the die must read value-2 (wrapped) when the button goes down.
    task automatic press_roll(input int k, input int value, output logic [1:0] st_at,
                              output logic rv_at, output logic [2:0] lr_at,
                              output logic rv_after, output logic tr_after);
        int pre;
        logic [1:0] st, cp;
        logic [2:0] lr;
        logic rv, tr;
        pre = ((value - 3 + FACES) % FACES) + 1;
        for (int g = 0; g < 2 * FACES && die_m != pre; g++) tick();
        roll_n[k] = 1'b0;
        tick(); tick(); tick();
        sample(k, st, cp, lr, rv, tr);
        st_at = st; rv_at = rv; lr_at = lr;
        roll_n[k] = 1'b1;
        tick();
        sample(k, st, cp, lr, rv, tr);
        rv_after = rv; tr_after = tr;
        tick(); tick();
    endtask

    logic [1:0] st_at;
    logic [2:0] lr_at;
    logic rv_at, rv_after, tr_after;

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; roll_n = 3'b111; new_n = 3'b111;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        n_vec++; if (st2 !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b want 00", st2); end
        n_vec++; if (cp2 !== 1'b0) begin n_bad++; $display("FAIL reset_cur: got %b want 0", cp2); end
        n_vec++; if (lr2 !== 3'd0 || rv2 !== 1'b0) begin n_bad++; $display("FAIL reset_roll: got lr=%0d rv=%b want 0/0", lr2, rv2); end
        n_vec++; if (sc2 !== 6'd0 || wm2 !== 2'b00) begin n_bad++; $display("FAIL reset_scores: got sc=%b wm=%b want 0/0", sc2, wm2); end
        enable = 1'b1;
        tick();
        n_vec++; if (st2 !== 2'b01 || st3 !== 2'b01 || st4 !== 2'b01) begin n_bad++; $display("FAIL enable_roll: got %b %b %b want 01", st2, st3, st4); end
        n_vec++; if (cp2 !== 1'b0 || sc2 !== 6'd0 || lr2 !== 3'd0) begin n_bad++; $display("FAIL enable_clear: got cp=%b sc=%b lr=%0d want 0", cp2, sc2, lr2); end
    endtask

    task automatic test_round();
        press_roll(0, 5, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (rv_at !== 1'b1 || lr_at !== 3'd5) begin n_bad++; $display("FAIL r1_p0_roll: got rv=%b lr=%0d want 1/5", rv_at, lr_at); end
        n_vec++; if (rv_after !== 1'b0) begin n_bad++; $display("FAIL r1_pulse_width: got %b want 0", rv_after); end
        n_vec++; if (cp2 !== 1'b1 || st2 !== 2'b01) begin n_bad++; $display("FAIL r1_next_player: got cp=%b st=%b want 1/01", cp2, st2); end
        press_roll(0, 2, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (rv_at !== 1'b1 || lr_at !== 3'd2) begin n_bad++; $display("FAIL r1_p1_roll: got rv=%b lr=%0d want 1/2", rv_at, lr_at); end
        n_vec++; if (st_at !== 2'b10) begin n_bad++; $display("FAIL r1_score_state: got %b want 10", st_at); end
        n_vec++; if (st2 !== 2'b01 || cp2 !== 1'b0) begin n_bad++; $display("FAIL r1_back_to_roll: got st=%b cp=%b want 01/0", st2, cp2); end
        n_vec++; if (sc2 !== 6'b000_001) begin n_bad++; $display("FAIL r1_scores: got %b want 000001", sc2); end
    endtask

    task automatic test_tie();
        press_roll(0, 4, st_at, rv_at, lr_at, rv_after, tr_after);
        press_roll(0, 4, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (st2 !== 2'b01) begin n_bad++; $display("FAIL tie_state: got %b want 01", st2); end
`ifdef DICE_TIE_REROLL_EN
        n_vec++; if (tr_after !== 1'b1) begin n_bad++; $display("FAIL tie_pulse: got %b want 1", tr_after); end
        n_vec++; if (sc2 !== 6'b000_001) begin n_bad++; $display("FAIL tie_scores: got %b want 000001", sc2); end
`else
        n_vec++; if (sc2 !== 6'b001_010) begin n_bad++; $display("FAIL tie_scores: got %b want 001010", sc2); end
`endif
    endtask

    task automatic test_win();
        for (int v = 1; v <= 3; v++) press_roll(1, v, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (sc3 !== 6'b01_00_00 || st3 !== 2'b01) begin n_bad++; $display("FAIL win_r1: got sc=%b st=%b want 010000/01", sc3, st3); end
        for (int v = 1; v <= 3; v++) press_roll(1, v, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (st3 !== 2'b11) begin n_bad++; $display("FAIL win_state: got %b want 11", st3); end
        n_vec++; if (wm3 !== 3'b100) begin n_bad++; $display("FAIL win_mask: got %b want 100", wm3); end
        n_vec++; if (sc3 !== 6'b10_00_00 || lr3 !== 3'd0) begin n_bad++; $display("FAIL win_hold: got sc=%b lr=%0d want 100000/0", sc3, lr3); end
        press_roll(1, 6, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (rv_at !== 1'b0 || lr_at !== 3'd0 || st_at !== 2'b11) begin n_bad++; $display("FAIL won_ignores_roll: got rv=%b lr=%0d st=%b want 0/0/11", rv_at, lr_at, st_at); end
        new_n[1] = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (st3 !== 2'b01 || sc3 !== 6'd0 || wm3 !== 3'd0 || cp3 !== 2'd0) begin n_bad++; $display("FAIL new_game: got st=%b sc=%b wm=%b cp=%0d want 01/0/0/0", st3, sc3, wm3, cp3); end
        new_n[1] = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_tie_win();
        press_roll(2, 3, st_at, rv_at, lr_at, rv_after, tr_after);
        press_roll(2, 3, st_at, rv_at, lr_at, rv_after, tr_after);
`ifdef DICE_TIE_REROLL_EN
        n_vec++; if (sc4 !== 4'b00_00 || tr_after !== 1'b1) begin n_bad++; $display("FAIL tiewin_r1: got sc=%b tr=%b want 0000/1", sc4, tr_after); end
`else
        n_vec++; if (sc4 !== 4'b01_01) begin n_bad++; $display("FAIL tiewin_r1: got sc=%b want 0101", sc4); end
`endif
        press_roll(2, 6, st_at, rv_at, lr_at, rv_after, tr_after);
        press_roll(2, 6, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (lr_at !== 3'd6) begin n_bad++; $display("FAIL tiewin_face6: got %0d want 6", lr_at); end
`ifdef DICE_TIE_REROLL_EN
        n_vec++; if (st4 !== 2'b01 || wm4 !== 2'b00 || sc4 !== 4'b00_00) begin n_bad++; $display("FAIL tiewin_final: got st=%b wm=%b sc=%b want 01/00/0000", st4, wm4, sc4); end
`else
        n_vec++; if (st4 !== 2'b11 || wm4 !== 2'b11 || sc4 !== 4'b10_10) begin n_bad++; $display("FAIL tiewin_final: got st=%b wm=%b sc=%b want 11/11/1010", st4, wm4, sc4); end
`endif
    endtask

    task automatic test_enable();
        press_roll(0, 3, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (cp2 !== 1'b1 || lr2 !== 3'd3) begin n_bad++; $display("FAIL en_pre: got cp=%b lr=%0d want 1/3", cp2, lr2); end
        enable = 1'b0;
        tick();
        n_vec++; if (st2 !== 2'b00 || st3 !== 2'b00) begin n_bad++; $display("FAIL en_off: got %b %b want 00", st2, st3); end
        n_vec++; if (cp2 !== 1'b0 || lr2 !== 3'd0 || sc2 !== 6'd0 || wm2 !== 2'd0) begin n_bad++; $display("FAIL en_clear: got cp=%b lr=%0d sc=%b wm=%b want 0", cp2, lr2, sc2, wm2); end
        enable = 1'b1;
        tick();
        n_vec++; if (st2 !== 2'b01) begin n_bad++; $display("FAIL en_back: got %b want 01", st2); end
    endtask

    task automatic test_same_cycle();
        press_roll(0, 1, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (lr_at !== 3'd1 || cp2 !== 1'b1) begin n_bad++; $display("FAIL sc_pre: got lr=%0d cp=%b want 1/1", lr_at, cp2); end
        roll_n[0] = 1'b0; new_n[0] = 1'b0;
        tick(); tick(); tick();
        n_vec++; if (rv2 !== 1'b0 || cp2 !== 1'b0 || st2 !== 2'b01) begin n_bad++; $display("FAIL newgame_priority: got rv=%b cp=%b st=%b want 0/0/01", rv2, cp2, st2); end
        roll_n[0] = 1'b1; new_n[0] = 1'b1;
        repeat (3) tick();
        press_roll(0, 2, st_at, rv_at, lr_at, rv_after, tr_after);
        press_roll(0, 5, st_at, rv_at, lr_at, rv_after, tr_after);
        n_vec++; if (st_at !== 2'b10 || sc2 !== 6'b001_000) begin n_bad++; $display("FAIL after_restart: got st=%b sc=%b want 10/001000", st_at, sc2); end
    endtask

    initial begin
        test_reset();
        test_round();
        test_tie();
        test_win();
        test_tie_win();
        test_enable();
        test_same_cycle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
